// File: rtl/rr_reg_bank_arbiter.sv
// Round-robin arbiter that gives NREQ requesters serialised single-access
// use of a small DFF register bank (one read or write per grant).
module rr_reg_bank_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 8,
  parameter int AW   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      we,
  input  logic [NREQ*AW-1:0]   addr,
  input  logic [NREQ*DW-1:0]   wdata,
  output logic [NREQ-1:0]      gnt,
  output logic [DW-1:0]        rdata,
  output logic                 rvalid,
  output logic                 busy
);

  localparam int unsigned NR    = NREQ;
  localparam int unsigned PW    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned DEPTH = 1 << AW;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] ptr;
  logic [PW-1:0] win;
  logic [PW-1:0] sel;
  logic          any_req;
  logic          we_w;
  logic [AW-1:0] addr_w;
  logic [DW-1:0] wdata_w;
  logic [DW-1:0] bank [DEPTH];

  assign any_req = |req;

  // Winner search: first requester at or after ptr, wrapping around.
  always_comb begin
    logic          found;
    logic [PW-1:0] cand;
    found = 1'b0;
    cand  = '0;
    sel   = '0;
    for (int unsigned k = 0; k < NR; k++) begin
      cand = PW'((32'(ptr) + k) % NR);
      if (!found && req[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  // Winner's access fields, picked live so they are sampled at the ACCESS edge.
  always_comb begin
    we_w    = 1'b0;
    addr_w  = '0;
    wdata_w = '0;
    for (int unsigned i = 0; i < NR; i++) begin
      if (win == PW'(i)) begin
        we_w    = we[i];
        addr_w  = addr[i*AW +: AW];
        wdata_w = wdata[i*DW +: DW];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: one cycle in ACCESS per grant, then a mandatory IDLE cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ACCESS;
      ACCESS:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State-derived outputs.
  always_comb begin
    busy = (state == ACCESS);
  end

  // Grant, winner latch, round-robin pointer and read-return registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt    <= '0;
      win    <= '0;
      ptr    <= '0;
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          rvalid <= 1'b0;
          if (any_req) begin
            gnt <= {{(NREQ-1){1'b0}}, 1'b1} << sel;
            win <= sel;
          end
        end
        ACCESS: begin
          gnt <= '0;
          ptr <= (win == PW'(NR - 1)) ? '0 : win + 1'b1;
          if (we_w) begin
            rvalid <= 1'b0;
          end else begin
            rdata  <= bank[addr_w];
            rvalid <= 1'b1;
          end
        end
        default: begin
          gnt    <= '0;
          rvalid <= 1'b0;
        end
      endcase
    end
  end

  // Register bank: only the granted requester's write lands, at the ACCESS edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned j = 0; j < DEPTH; j++) bank[j] <= '0;
    end else if (state == ACCESS && we_w) begin
      bank[addr_w] <= wdata_w;
    end
  end

endmodule

// File: tb/tb_rr_reg_bank_arbiter.sv
// Self-checking bench for rr_reg_bank_arbiter against a transaction-level model.
module tb_rr_reg_bank_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int AW   = 2;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NREQ-1:0]     req;
  logic [NREQ-1:0]     we;
  logic [NREQ*AW-1:0]  addr;
  logic [NREQ*DW-1:0]  wdata;
  logic [NREQ-1:0]     gnt;
  logic [DW-1:0]       rdata;
  logic                rvalid;
  logic                busy;

  int tests = 0;
  int fails = 0;

  // reference model state
  logic [DW-1:0] m_bank [1<<AW];
  int            m_ptr;
  logic [DW-1:0] m_rdata;

  // observations from one arbitration round
  logic [NREQ-1:0] o_g1, o_g2;
  logic            o_b1, o_b2, o_rv1, o_rv2;
  logic [DW-1:0]   o_rd2;

  rr_reg_bank_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rdata(rdata), .rvalid(rvalid), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic int model_winner(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++)
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int w);
    logic [NREQ-1:0] v;
    v = '0;
    if (w >= 0) v[w] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    for (int a = 0; a < (1 << AW); a++) m_bank[a] = '0;
    m_ptr   = 0;
    m_rdata = '0;
  endtask

  // Predict the outcome of the next grant from the current request inputs.
  task automatic predict(output int ew, output logic erv);
    int a;
    ew  = model_winner(req, m_ptr);
    erv = 1'b0;
    if (ew >= 0) begin
      a = int'(addr[ew*AW +: AW]);
      if (we[ew]) m_bank[a] = wdata[ew*DW +: DW];
      else begin
        m_rdata = m_bank[a];
        erv     = 1'b1;
      end
      m_ptr = (ew + 1) % NREQ;
    end
  endtask

  task automatic set_req(input int i, input bit w, input int a, input int d);
    req[i]             = 1'b1;
    we[i]              = w;
    addr[i*AW +: AW]   = AW'(a);
    wdata[i*DW +: DW]  = DW'(d);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  // One IDLE edge plus one ACCESS edge; samples 1 time unit after each.
  task automatic round(input bit drop);
    @(posedge clk); #1;
    o_g1 = gnt; o_b1 = busy; o_rv1 = rvalid;
    @(posedge clk); #1;
    o_g2 = gnt; o_b2 = busy; o_rv2 = rvalid; o_rd2 = rdata;
    if (drop)
      for (int i = 0; i < NREQ; i++) if (o_g1[i]) req[i] = 1'b0;
  endtask

  task automatic test_reset();
    int ew; logic erv;
    do_reset();
    tests++; if (gnt !== '0) begin fails++; $display("FAIL reset_gnt: got %b want 0", gnt); end
    tests++; if (rvalid !== 1'b0) begin fails++; $display("FAIL reset_rvalid: got %b want 0", rvalid); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests++; if (rdata !== '0) begin fails++; $display("FAIL reset_rdata: got %h want 00", rdata); end
    for (int a = 0; a < (1 << AW); a++) begin
      set_req(0, 1'b0, a, 0);
      predict(ew, erv);
      round(1'b1);
      tests++; if (o_rv2 !== 1'b1 || o_rd2 !== 8'h00) begin
        fails++; $display("FAIL reset_read%0d: got rv=%b rd=%h want rv=1 rd=00", a, o_rv2, o_rd2);
      end
    end
  endtask

  task automatic test_single_rw();
    int ew; logic erv;
    set_req(1, 1'b1, 2, 8'hA5);
    predict(ew, erv);
    round(1'b1);
    tests++; if (o_g1 !== 4'b0010 || o_b1 !== 1'b1) begin
      fails++; $display("FAIL single_wr_gnt: got gnt=%b busy=%b want 0010/1", o_g1, o_b1);
    end
    tests++; if (o_g2 !== '0 || o_b2 !== 1'b0 || o_rv2 !== 1'b0) begin
      fails++; $display("FAIL single_wr_end: got gnt=%b busy=%b rv=%b want 0000/0/0", o_g2, o_b2, o_rv2);
    end
    set_req(1, 1'b0, 2, 0);
    predict(ew, erv);
    round(1'b1);
    tests++; if (o_rv1 !== 1'b0 || o_rv2 !== 1'b1 || o_rd2 !== 8'hA5) begin
      fails++; $display("FAIL single_rd: got rv=%b/%b rd=%h want 0/1 A5", o_rv1, o_rv2, o_rd2);
    end
  endtask

  task automatic test_all_four();
    int ew; logic erv;
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, i, 8'h10 + i);
    for (int i = 0; i < NREQ; i++) begin
      predict(ew, erv);
      round(1'b1);
      tests++; if (o_g1 !== onehot(i) || o_g2 !== '0) begin
        fails++; $display("FAIL all4_gnt%0d: got %b then %b want %b then 0000", i, o_g1, o_g2, onehot(i));
      end
    end
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, i, 0);
    for (int i = 0; i < NREQ; i++) begin
      predict(ew, erv);
      round(1'b1);
      tests++; if (o_rv2 !== 1'b1 || o_rd2 !== DW'(8'h10 + i)) begin
        fails++; $display("FAIL all4_rd%0d: got rv=%b rd=%h want 1 %h", i, o_rv2, o_rd2, 8'h10 + i);
      end
    end
  endtask

  task automatic test_wrap_fairness();
    int ew; logic erv;
    logic [NREQ-1:0] prev;
    set_req(3, 1'b0, 0, 0);
    set_req(0, 1'b0, 1, 0);
    predict(ew, erv); round(1'b1);
    tests++; if (o_g1 !== 4'b0001) begin fails++; $display("FAIL wrap_first: got %b want 0001", o_g1); end
    predict(ew, erv); round(1'b1);
    tests++; if (o_g1 !== 4'b1000) begin fails++; $display("FAIL wrap_second: got %b want 1000", o_g1); end
    set_req(0, 1'b0, 0, 0);
    set_req(2, 1'b0, 3, 0);
    prev = '0;
    for (int r = 0; r < 6; r++) begin
      predict(ew, erv);
      round(1'b0);
      tests++; if (o_g1 !== onehot(ew) || o_g1 === prev) begin
        fails++; $display("FAIL alternate%0d: got %b prev %b want %b", r, o_g1, prev, onehot(ew));
      end
      prev = o_g1;
    end
    req = '0;
  endtask

  task automatic test_reset_mid_access();
    int ew; logic erv;
    set_req(1, 1'b1, 1, 8'hFF);
    @(posedge clk); #1;
    tests++; if (gnt !== 4'b0010 || busy !== 1'b1) begin
      fails++; $display("FAIL midrst_grant: got gnt=%b busy=%b want 0010/1", gnt, busy);
    end
    #2 rst = 1'b1;
    #1;
    tests++; if (gnt !== '0 || busy !== 1'b0 || rvalid !== 1'b0 || rdata !== '0) begin
      fails++; $display("FAIL midrst_async: got gnt=%b busy=%b rv=%b rd=%h want all 0", gnt, busy, rvalid, rdata);
    end
    req = '0;
    @(posedge clk); #1 rst = 1'b0;
    model_reset();
    set_req(0, 1'b0, 1, 0);
    set_req(2, 1'b0, 1, 0);
    predict(ew, erv); round(1'b1);
    tests++; if (o_g1 !== 4'b0001 || o_rv2 !== 1'b1 || o_rd2 !== 8'h00) begin
      fails++; $display("FAIL midrst_after: got gnt=%b rv=%b rd=%h want 0001/1/00", o_g1, o_rv2, o_rd2);
    end
    predict(ew, erv); round(1'b1);
    tests++; if (o_g1 !== 4'b0100) begin fails++; $display("FAIL midrst_second: got %b want 0100", o_g1); end
  endtask

  task automatic test_isolation();
    int ew; logic erv;
    set_req(0, 1'b1, 0, 8'h3C);
    predict(ew, erv); round(1'b1);
    set_req(1, 1'b0, 0, 0);
    set_req(2, 1'b1, 0, 8'h55);
    predict(ew, erv); round(1'b1);
    tests++; if (o_g1 !== 4'b0010 || o_rv2 !== 1'b1 || o_rd2 !== 8'h3C) begin
      fails++; $display("FAIL isolate_read: got gnt=%b rv=%b rd=%h want 0010/1/3C", o_g1, o_rv2, o_rd2);
    end
    predict(ew, erv); round(1'b1);
    tests++; if (o_g1 !== 4'b0100 || o_rv2 !== 1'b0 || o_rd2 !== 8'h3C) begin
      fails++; $display("FAIL isolate_wr: got gnt=%b rv=%b rd=%h want 0100/0/3C", o_g1, o_rv2, o_rd2);
    end
    set_req(3, 1'b0, 0, 0);
    predict(ew, erv); round(1'b1);
    tests++; if (o_rv2 !== 1'b1 || o_rd2 !== 8'h55) begin
      fails++; $display("FAIL isolate_after: got rv=%b rd=%h want 1/55", o_rv2, o_rd2);
    end
  endtask

  task automatic test_random();
    int ew; logic erv;
    logic [NREQ-1:0] saved;
    for (int r = 0; r < 80; r++) begin
      for (int i = 0; i < NREQ; i++)
        if (!req[i] && $urandom_range(1, 0) == 1)
          set_req(i, 1'(($urandom_range(1, 0))), $urandom_range((1 << AW) - 1, 0), $urandom_range(255, 0));
      if (req == '0)
        set_req($urandom_range(NREQ - 1, 0), 1'b0, $urandom_range((1 << AW) - 1, 0), 0);
      predict(ew, erv);
      round(1'b1);
      tests++; if (o_g1 !== onehot(ew) || o_b1 !== 1'b1 || o_rv1 !== 1'b0) begin
        fails++; $display("FAIL rand_grant%0d: got gnt=%b busy=%b rv=%b want %b/1/0", r, o_g1, o_b1, o_rv1, onehot(ew));
      end
      tests++; if (o_g2 !== '0 || o_b2 !== 1'b0 || o_rv2 !== erv || o_rd2 !== m_rdata) begin
        fails++; $display("FAIL rand_access%0d: got gnt=%b busy=%b rv=%b rd=%h want 0000/0/%b/%h",
                          r, o_g2, o_b2, o_rv2, o_rd2, erv, m_rdata);
      end
      if ($urandom_range(3, 0) == 0) begin
        saved = req;
        req   = '0;
        @(posedge clk); #1;
        tests++; if (gnt !== '0 || busy !== 1'b0 || rvalid !== 1'b0) begin
          fails++; $display("FAIL rand_idle%0d: got gnt=%b busy=%b rv=%b want 0/0/0", r, gnt, busy, rvalid);
        end
        req = saved;
      end
    end
    req = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    req = '0; we = '0; addr = '0; wdata = '0;
    model_reset();
    test_reset();
    test_single_rw();
    test_all_four();
    test_wrap_fairness();
    test_reset_mid_access();
    test_isolation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rr_reg_bank_arbiter.md
Name: rr_reg_bank_arbiter

Overview:
- Shares one small bank of D-flip-flop storage registers between NREQ requesters.
- Arbitration is round-robin.
- Each granted requester performs exactly one access, either a read or a write, per grant.
- The block sits between several producer/consumer blocks and a common configuration/status register bank. It serialises their accesses so that no two requesters ever touch the bank in the same cycle.

Parameters:
- NREQ, 4, number of requesters (2..8)
- DW, 8, data width of each register
- AW, 2, address width; the bank holds 2**AW registers

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- req  input  NREQ  per-requester access request, level
- we  input  NREQ  per-requester write enable: 1 = write, 0 = read
- addr  input  NREQ*AW  per-requester address; requester i uses bits [i*AW +: AW]
- wdata  input  NREQ*DW  per-requester write data; requester i uses bits [i*DW +: DW]
- gnt  output  NREQ  one-hot grant, registered
- rdata  output  DW  read data, registered
- rvalid  output  1  one-cycle pulse, rdata valid
- busy  output  1  high while an access is in progress (state ACCESS)

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state = IDLE
  - gnt = 0, rdata = 0, rvalid = 0, busy = 0
  - round-robin pointer ptr = 0
  - all bank registers = 0
- State machine has two states, IDLE and ACCESS. busy = (state == ACCESS).
- IDLE, rising edge with req != 0:
  - Select winner w = first i with req[i] = 1, scanning ptr, ptr+1, ..., NREQ-1, 0, ..., ptr-1.
  - gnt <= one-hot(w); latch w; state <= ACCESS.
- IDLE, rising edge with req == 0: remain in IDLE, gnt stays 0.
- ACCESS, next rising edge (exactly one cycle in ACCESS):
  - If we[w] = 1: bank[addr_w] <= wdata_w; rvalid stays 0.
  - If we[w] = 0: rdata <= bank[addr_w]; rvalid <= 1.
  - gnt <= 0; ptr <= (w+1) mod NREQ (so winner NREQ-1 wraps ptr to 0); state <= IDLE.
- Latency:
  - Request sampled at edge E1; gnt high from E1 to E2.
  - Write committed at E2.
  - Read data and rvalid high from E2 to E3.
  - rvalid clears at E3 unless a new read completes at that edge.
- Throughput: at most one access per 2 cycles, because there is a mandatory IDLE cycle after every ACCESS.
- Requester protocol:
  - Hold req, we, addr and wdata stable from req assertion until gnt is seen.
  - Deassert req in the cycle after gnt (before the next sampling edge), unless a further access is wanted.
  - A req still high at the IDLE edge is treated as a new request.
- Sampling: we/addr/wdata of the winner are sampled at the ACCESS edge, not at the IDLE edge.
- Losing requesters keep req high and wait. No requester waits more than NREQ grants.
- Read-after-write to the same address by any requester returns the new value; there is no bypass requirement within a single edge.
- Inputs of non-granted requesters never affect bank, rdata or rvalid.
- rst asserted during ACCESS: the pending write or read is abandoned, and all outputs and the bank return to their reset values immediately.
- gnt is always one-hot or zero. It is never asserted in IDLE and never multi-hot.

Test Plan:
- Reset check: assert rst for 2 cycles, then release → gnt=0, rvalid=0, busy=0, rdata=0; a read of every address returns 0x00.
- Single write/read by requester 1:
  - Write addr=2, wdata=0xA5 → gnt=4'b0010 for exactly one cycle, busy high in that same cycle.
  - Read addr=2 → rvalid pulses one cycle later with rdata=0xA5.
- All 4 requesters request simultaneously from ptr=0, each writing value 0x10+i to addr i, each dropping req after its grant:
  - Grants 0001, 0010, 0100, 1000 on every other cycle.
  - Subsequent reads return 0x10, 0x11, 0x12, 0x13.
- Wrap and fairness: after requester 3 is granted (ptr=0), requesters 3 and 0 both request → grant 0 first, then 3. Continuous req from requester 2 alongside requester 0 → strictly alternating grants.
- Reset mid-access:
  - Write addr=1, 0xFF is granted; rst is asserted during the ACCESS cycle.
  - → gnt and busy fall immediately; a read of addr 1 after reset returns 0x00; ptr is 0, so a simultaneous req from requesters 0 and 2 grants requester 0 first.
- Non-winner isolation: requester 2 holds we=1, addr=0, wdata=0x55 while requester 1's read of addr 0 is granted → rdata returns the prior value, not 0x55, and bank[0] is unchanged until requester 2 is granted.
